mac_grid_n: RTL and testbench
=============================

# mac_grid_n

Parametrised multi-channel multiply-accumulate grid, the next generation of the single-channel `grid_1` MAC core behind the padring top. It receives one shared input stream and applies a per-channel weight and bias to every sample of a frame. At the end of each frame it emits one saturated result per channel through a ready/valid output port, so the channel count can grow without adding pads. Weights and biases are loaded at run time through a narrow configuration port.

## Interface
- `DATA_W`, 8: width of samples, weights, biases and results.
- `CH`, 4: number of channels. Must be 2 or more.
- `ACC_W`, 20: accumulator width. Must be at least 2*DATA_W.
- `SHIFT`, 0: arithmetic right shift applied before saturation.
- `clk` input 1: the only clock. Every output is registered on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `din` input DATA_W: input sample.
- `din_valid` input 1: marks a valid sample beat.
- `din_last` input 1: marks the final beat of a frame. Qualified by `din_valid`.
- `din_ready` output 1: the block accepts a beat when `din_valid & din_ready` is high.
- `sign` input 1: selects two's-complement arithmetic (1) or unsigned arithmetic (0).
- `trig` input 1: aborts the current frame and clears the accumulators.
- `cfg_we` input 1: configuration write strobe.
- `cfg_kind` input 1: selects the target of a write. 0 writes a weight, 1 writes a bias.
- `cfg_sel` input clog2(CH): channel index of the write.
- `cfg_data` input DATA_W: configuration value.
- `dout` output DATA_W: result value.
- `dout_ch` output clog2(CH): channel index of `dout`.
- `dout_valid` output 1: result is valid.
- `dout_ready` input 1: downstream consumer accepts the result.

## Operation
- The state machine has two states, ACCUM and DRAIN.
- **ACCUM**
  - `din_ready` is 1.
  - Each accepted beat updates every channel: acc[c] += din × w[c].
  - The product is signed or unsigned according to the frame sign, is 2*DATA_W wide, and is extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W.
- **Frame sign**
  - The frame sign is latched from `sign` on the first beat of a frame.
  - It is used for every product and for the output saturation of that frame.
- **Frame end**
  - An accepted beat with `din_last` set includes its own product.
  - On that beat the block computes r[c] = sat((acc[c] + product + bias[c]) >>> SHIFT) into output registers.
  - The bias is sign-extended or zero-extended according to the frame sign.
  - The accumulators are then cleared and the state moves to DRAIN.
  - A frame of a single beat is legal.
- **Saturation**
  - Signed frames clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Unsigned frames clamp to [0, 2^DATA_W-1].
- **DRAIN**
  - `din_ready` is 0 and `dout_valid` is 1.
  - `dout` = r[k] and `dout_ch` = k.
  - k starts at 0 and advances on each cycle where `dout_valid & dout_ready` is high.
  - The handshake on k = CH-1 returns the state to ACCUM.
  - `dout` and `dout_ch` hold steady while `dout_ready` is 0.
- **trig**
  - In ACCUM, `trig` clears all accumulators and restarts the frame.
  - A beat accepted in the same cycle as `trig` becomes the first beat of the new frame: acc = product, and the frame sign is re-latched.
  - If that beat also has `din_last` set, it forms a one-beat frame.
  - In DRAIN, `trig` is ignored.
- **Configuration writes**
  - Writes are accepted in either state.
  - A write in cycle t takes effect for beats or captures from cycle t+1 onward.
  - A capture in cycle t uses the bias value held before the edge at the end of cycle t.

## Timing
- Reset values:
  - state ACCUM.
  - acc, w and bias all 0.
  - `din_ready` 1.
  - `dout_valid` 0, `dout` 0, `dout_ch` 0.
- Latency: a last beat accepted in cycle t produces `dout_valid` = 1 for ch0 in cycle t+1.
- With `dout_ready` held at 1, channel CH-1 appears in cycle t+CH.
- `din_ready` returns to 1 in cycle t+CH+1.
- Minimum frame period is frame_beats + CH cycles.
- Reset takes effect in every state. Asserting `rst` during DRAIN discards all pending results.
- `din_valid` while `din_ready` is 0 is ignored. No beat is stored.

## Configuration
- The macro `MAC_RELU_EN` controls an output ReLU.
- **Defined:** in signed frames, negative results are forced to 0 after saturation. This is a ReLU and costs one comparator per output path.
- **Not defined:** signed results are passed through with their sign. Unsigned frames behave the same in both builds.

## Test plan
All scenarios use CH=4, DATA_W=8, ACC_W=20 and SHIFT=0 unless stated.
1. **Unsigned frame.** Load w={1,2,3,4} and bias={0,0,0,5}; stream 10 then 20 (last), sign=0. Required: `dout` 30, 60, 90, 125 with `dout_ch` 0..3; the first result appears one cycle after the last beat.
2. **Signed saturation.** Load w0=0x80 (-128) and w1=1; stream 127, 127 (last), sign=1. Required: ch0 = 0x80 (-128), clamped from -32512; ch1 = 0x7F (127), clamped from 254.
3. **Backpressure.** Drop `dout_ready` for 3 cycles during ch1. Required: `dout`/`dout_ch` hold ch1, `din_ready` stays 0, and `din_valid` pulses are ignored. After release, ch2 and ch3 follow on consecutive cycles.
4. **trig mid-frame.** With w0=1, stream 50, then pulse `trig` together with beat 7, then beat 3 (last). Required: ch0 = 10.
5. **Reset mid-drain.** Assert `rst` while ch2 is pending. Required: next cycle `dout_valid` = 0, `din_ready` = 1, and all weights and biases read as 0, so a subsequent frame outputs 0 on every channel.
6. **`MAC_RELU_EN`.** Signed frame with w0 = -1, stream 5 (last). Required: ch0 = 0 with the macro defined and ch0 = 0xFB (-5) without it.

Source files
------------

// File: rtl/mac_grid_n.sv
// mac_grid_n: one shared sample stream, per-channel weight/bias MAC with per-frame saturated
// results drained through a ready/valid port. Define MAC_RELU_EN to zero negative signed results.
module mac_grid_n #(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic                  din_ready,
  input  logic                  sign,
  input  logic                  trig,
  input  logic                  cfg_we,
  input  logic                  cfg_kind,
  input  logic [$clog2(CH)-1:0] cfg_sel,
  input  logic [DATA_W-1:0]     cfg_data,
  output logic [DATA_W-1:0]     dout,
  output logic [$clog2(CH)-1:0] dout_ch,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int SEL_W = $clog2(CH);
  localparam int EXT_W = ACC_W - 2 * DATA_W;
  localparam logic [ACC_W-1:0] S_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] U_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q    [CH];
  logic [DATA_W-1:0] w_q      [CH];
  logic [DATA_W-1:0] bias_q   [CH];
  logic [DATA_W-1:0] res_q    [CH];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [SEL_W-1:0]  k_q, k_d;
  logic [SEL_W-1:0]  k_inc;
  logic              dout_valid_q, dout_valid_d;
  logic              first_q, first_d;
  logic              frame_sign_q, frame_sign_d;

  logic              acc_clear, acc_load, res_load;
  logic              beat, first_beat, beat_sign;
  logic [2*DATA_W-1:0] din_e;
  logic [ACC_W-1:0]  acc_upd  [CH];
  logic [DATA_W-1:0] res_calc [CH];

  assign beat       = din_valid && (state_q == ACCUM);
  // A trig cycle restarts the frame, so its beat (if any) re-latches the sign.
  assign first_beat = first_q || trig;
  assign beat_sign  = first_beat ? sign : frame_sign_q;
  assign din_e      = {{DATA_W{beat_sign & din[DATA_W-1]}}, din};
  assign k_inc      = k_q + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [2*DATA_W-1:0] w_e;
      logic [2*DATA_W-1:0] prod;
      logic [ACC_W-1:0]    prod_x;
      logic [ACC_W-1:0]    bias_x;
      logic [ACC_W-1:0]    base;
      logic [ACC_W-1:0]    sum;
      logic [ACC_W-1:0]    shifted;
      logic [DATA_W-1:0]   sat;

      // Low 2*DATA_W bits of the extended-operand product are exact for both signednesses.
      assign w_e     = {{DATA_W{beat_sign & w_q[gi][DATA_W-1]}}, w_q[gi]};
      assign prod    = din_e * w_e;
      assign prod_x  = {{(EXT_W+1){beat_sign & prod[2*DATA_W-1]}}, prod[2*DATA_W-2:0]};
      assign bias_x  = {{(ACC_W-DATA_W){beat_sign & bias_q[gi][DATA_W-1]}}, bias_q[gi]};
      assign base    = first_beat ? '0 : acc_q[gi];
      assign sum     = acc_upd[gi] + bias_x;
      assign shifted = beat_sign ? $unsigned($signed(sum) >>> SHIFT) : (sum >> SHIFT);
      assign acc_upd[gi] = base + prod_x;

      always_comb begin
        if (beat_sign) begin
          if ($signed(shifted) > $signed(S_MAX)) begin
            sat = S_MAX[DATA_W-1:0];
          end else if ($signed(shifted) < $signed(S_MIN)) begin
            sat = S_MIN[DATA_W-1:0];
          end else begin
            sat = shifted[DATA_W-1:0];
          end
`ifdef MAC_RELU_EN
          if (sat[DATA_W-1]) begin
            sat = '0;
          end
`endif
        end else begin
          sat = (shifted > U_MAX) ? U_MAX[DATA_W-1:0] : shifted[DATA_W-1:0];
        end
      end

      assign res_calc[gi] = sat;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    first_d      = first_q;
    frame_sign_d = frame_sign_q;
    acc_clear    = 1'b0;
    acc_load     = 1'b0;
    res_load     = 1'b0;
    case (state_q)
      ACCUM: begin
        if (trig) begin
          first_d   = 1'b1;
          acc_clear = 1'b1;
        end
        if (beat) begin
          frame_sign_d = beat_sign;
          first_d      = 1'b0;
          acc_clear    = 1'b0;
          acc_load     = 1'b1;
          if (din_last) begin
            first_d      = 1'b1;
            acc_clear    = 1'b1;
            acc_load     = 1'b0;
            res_load     = 1'b1;
            state_d      = DRAIN;
            k_d          = '0;
            dout_d       = res_calc[0];
            dout_valid_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dout_ready) begin
          if (k_q == LAST_CH) begin
            state_d      = ACCUM;
            dout_valid_d = 1'b0;
          end else begin
            k_d    = k_inc;
            dout_d = res_q[k_inc];
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      k_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      first_q      <= 1'b1;
      frame_sign_q <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        acc_q[c]  <= '0;
        w_q[c]    <= '0;
        bias_q[c] <= '0;
        res_q[c]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      first_q      <= first_d;
      frame_sign_q <= frame_sign_d;
      for (int c = 0; c < CH; c++) begin
        if (acc_clear) begin
          acc_q[c] <= '0;
        end else if (acc_load) begin
          acc_q[c] <= acc_upd[c];
        end
        if (res_load) begin
          res_q[c] <= res_calc[c];
        end
        if (cfg_we && (cfg_sel == SEL_W'(c))) begin
          if (cfg_kind) begin
            bias_q[c] <= cfg_data;
          end else begin
            w_q[c] <= cfg_data;
          end
        end
      end
    end
  end

  assign din_ready  = (state_q == ACCUM);
  assign dout       = dout_q;
  assign dout_ch    = k_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mac_grid_n.sv
// Self-checking bench for mac_grid_n: directed vector table, multi-cycle corner sequences,
// and random frames against an arithmetic reference model.
module tb_mac_grid_n;
  localparam int DW = 8;
  localparam int CH = 4;
  localparam int AW = 20;
  localparam int SH = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_last = 1'b0;
  logic          din_ready;
  logic          sign = 1'b0;
  logic          trig = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_kind = 1'b0;
  logic [1:0]    cfg_sel = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [DW-1:0] dout;
  logic [1:0]    dout_ch;
  logic          dout_valid;
  logic          dout_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  mac_grid_n #(.DATA_W(DW), .CH(CH), .ACC_W(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .sign(sign), .trig(trig), .cfg_we(cfg_we), .cfg_kind(cfg_kind),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          sg;
    int          n;
    logic [31:0] w;
    logic [31:0] b;
    logic [63:0] beats;
    logic [31:0] expv;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference: exact integer sum, wrap to ACC_W, shift, then clamp.
  function automatic logic [7:0] model_ch(input logic [7:0] wv, input logic [7:0] bv,
                                          input bit sg, input int n, input logic [63:0] beats);
    longint s;
    longint m;
    logic [7:0] d;
    s = 0;
    m = longint'(1) << AW;
    for (int i = 0; i < n; i++) begin
      d = beats[i*8 +: 8];
      if (sg) s += longint'($signed(d)) * longint'($signed(wv));
      else    s += longint'(d) * longint'(wv);
    end
    if (sg) s += longint'($signed(bv));
    else    s += longint'(bv);
    s = s % m;
    if (s < 0) s += m;
    if (sg && s >= m / 2) s -= m;
    s = s >>> SH;
    if (sg) begin
      if (s > 127) s = 127;
      if (s < -128) s = -128;
`ifdef MAC_RELU_EN
      if (s < 0) s = 0;
`endif
    end else if (s > 255) begin
      s = 255;
    end
    return s[7:0];
  endfunction

  function automatic logic [31:0] relu_adj(input logic [31:0] v, input bit sg);
    logic [31:0] r;
    r = v;
`ifdef MAC_RELU_EN
    if (sg) begin
      for (int c = 0; c < CH; c++) begin
        if (r[c*8+7]) r[c*8 +: 8] = 8'h00;
      end
    end
`endif
    return r;
  endfunction

  task automatic cfg_write(input bit kind, input int sel, input logic [7:0] data);
    cfg_we = 1'b1;
    cfg_kind = kind;
    cfg_sel = sel[1:0];
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] w, input logic [31:0] b);
    for (int c = 0; c < CH; c++) cfg_write(1'b0, c, w[c*8 +: 8]);
    for (int c = 0; c < CH; c++) cfg_write(1'b1, c, b[c*8 +: 8]);
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit sg, input bit tr);
    din = d;
    din_valid = 1'b1;
    din_last = last;
    sign = sg;
    trig = tr;
    tick();
    din_valid = 1'b0;
    din_last = 1'b0;
    trig = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [63:0] beats, input bit sg);
    for (int i = 0; i < n; i++) send(beats[i*8 +: 8], (i == n - 1), sg, 1'b0);
  endtask

  // Called right after the last beat's edge: ch0 must already be valid.
  task automatic drain_check(input logic [31:0] expv, input string nm);
    logic [31:0] got;
    got = '0;
    for (int c = 0; c < CH; c++) begin
      check({nm, "_valid"}, {31'd0, dout_valid}, 32'd1);
      check({nm, "_ch"}, {30'd0, dout_ch}, c);
      check({nm, "_dout"}, {24'd0, dout}, {24'd0, expv[c*8 +: 8]});
      check({nm, "_busy"}, {31'd0, din_ready}, 32'd0);
      got[c*8 +: 8] = dout;
      tick();
    end
    check({nm, "_ready_back"}, {31'd0, din_ready}, 32'd1);
    check({nm, "_idle"}, {31'd0, dout_valid}, 32'd0);
    $display("frame %s: results %h expected %h", nm, got, expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, b, e;
    logic [63:0] bt;
    bit sg;
    int n;

    tbl[0] = '{"unsigned",       1'b0, 2, 32'h04030201, 32'h05000000, 64'h140A,   32'h7D5A3C1E};
    tbl[1] = '{"signed_sat",     1'b1, 2, 32'h00000180, 32'h00000000, 64'h7F7F,   32'h00007F80};
    tbl[2] = '{"unsigned_sat",   1'b0, 1, 32'hFF000102, 32'h00003700, 64'hC8,     32'hFF00FFFF};
    tbl[3] = '{"signed_edges",   1'b1, 1, 32'h00FF0101, 32'h80000100, 64'h7F,     32'h80817F7F};
    tbl[4] = '{"relu_case",      1'b1, 1, 32'h000000FF, 32'h00000000, 64'h05,     32'h000000FB};
    tbl[5] = '{"bias_sext",      1'b1, 1, 32'h00000002, 32'h000000FF, 64'h03,     32'h00000005};
    tbl[6] = '{"bias_zext",      1'b0, 1, 32'h00000002, 32'h000000FF, 64'h03,     32'h000000FF};
    tbl[7] = '{"multi_signed",   1'b1, 3, 32'h7F1003FE, 32'h00000000, 64'h02FB05, 32'h7F2006FC};

    repeat (3) tick();
    rst = 1'b0;
    check("reset_din_ready", {31'd0, din_ready}, 32'd1);
    check("reset_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_dout_ch", {30'd0, dout_ch}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      load_cfg(tbl[i].w, tbl[i].b);
      send_frame(tbl[i].n, tbl[i].beats, tbl[i].sg);
      drain_check(relu_adj(tbl[i].expv, tbl[i].sg), tbl[i].name);
    end

    // Backpressure during ch1; beats, last and trig during DRAIN are ignored.
    load_cfg(tbl[0].w, tbl[0].b);
    send_frame(2, 64'h140A, 1'b0);
    check("bp_ch0", {24'd0, dout}, 32'h1E);
    tick();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 8'h63;
      din_valid = 1'b1;
      din_last = (i == 2);
      trig = 1'b1;
      tick();
      check("bp_hold_ch", {30'd0, dout_ch}, 32'd1);
      check("bp_hold_dout", {24'd0, dout}, 32'h3C);
      check("bp_hold_valid", {31'd0, dout_valid}, 32'd1);
      check("bp_din_ready", {31'd0, din_ready}, 32'd0);
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    trig = 1'b0;
    dout_ready = 1'b1;
    tick();
    check("bp_ch2", {22'd0, dout_ch, dout}, {22'd0, 2'd2, 8'h5A});
    tick();
    check("bp_ch3", {22'd0, dout_ch, dout}, {22'd0, 2'd3, 8'h7D});
    tick();
    check("bp_done", {30'd0, din_ready, dout_valid}, 32'b10);
    $display("frame backpressure: held ch1 for 3 cycles");
    send_frame(2, 64'h140A, 1'b0);
    drain_check(32'h7D5A3C1E, "after_bp");

    // trig together with a beat restarts the frame on that beat.
    load_cfg(32'h00000201, 32'h0);
    send(8'd50, 1'b0, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b0, 1'b1);
    send(8'd3, 1'b1, 1'b0, 1'b0);
    drain_check(32'h0000140A, "trig_beat");
    // trig alone, then a signed one-beat frame.
    send(8'd50, 1'b0, 1'b0, 1'b0);
    din_valid = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    send(8'hFF, 1'b1, 1'b1, 1'b0);
    drain_check(relu_adj(32'h0000FEFF, 1'b1), "trig_alone");
    // trig beat re-latches the sign and is itself the last beat.
    send(8'd50, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b1, 1'b1);
    drain_check(relu_adj(32'h0000FEFF, 1'b1), "trig_last");

    // Config writes land from the next cycle onward.
    load_cfg(32'h00000001, 32'h0);
    cfg_we = 1'b1; cfg_kind = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd3;
    send(8'd5, 1'b0, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_kind = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd100;
    send(8'd2, 1'b1, 1'b0, 1'b0);
    cfg_we = 1'b0;
    drain_check(32'h0000000B, "cfg_timing");
    send(8'd1, 1'b1, 1'b0, 1'b0);
    drain_check(32'h00000067, "cfg_after");

    // Reset while ch2 is pending discards results and configuration.
    load_cfg(tbl[0].w, tbl[0].b);
    send_frame(2, 64'h140A, 1'b0);
    tick();
    tick();
    check("rst_pre_ch2", {30'd0, dout_ch}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd1);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_dout_ch", {30'd0, dout_ch}, 32'd0);
    send_frame(2, 64'h0409, 1'b0);
    drain_check(32'h0, "post_reset");

    // Random frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      w = $urandom();
      b = $urandom();
      bt = {$urandom(), $urandom()};
      sg = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 8);
      for (int c = 0; c < CH; c++) e[c*8 +: 8] = model_ch(w[c*8 +: 8], b[c*8 +: 8], sg, n, bt);
      load_cfg(w, b);
      send_frame(n, bt, sg);
      drain_check(e, $sformatf("rand%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
